// File: rtl/lenet_input_reader.sv
// Streams one padded CNN frame out of the capture buffer: pad pixels are synthesised,
// interior pixels are read one cycle ahead and queued in a 2-entry output FIFO.
module lenet_input_reader #(
  parameter int unsigned CNN_REAL_WIDTH  = 32,
  parameter int unsigned CNN_REAL_HEIGHT = 32,
  parameter int unsigned CNN_INPUT_PAD   = 2,
  parameter logic [7:0]  PAD_VALUE       = 8'h00
) (
  input  logic       clk25,
  input  logic       rst_n,
  input  logic       start,
  input  logic       lenet_data_ready,
  output logic       lenet_doing_signal,
  output logic [9:0] rd_addr,
  output logic       rd_en,
  input  logic [7:0] rd_data,
  output logic [7:0] px_data,
  output logic       px_valid,
  input  logic       px_ready,
  output logic       px_last,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned N        = CNN_REAL_WIDTH * CNN_REAL_HEIGHT;
  localparam logic [9:0]  LAST_IDX = 10'(N - 1);
  localparam logic [9:0]  COL_MAX  = 10'(CNN_REAL_WIDTH - 1);
  localparam logic [9:0]  PAD_LO   = 10'(CNN_INPUT_PAD);
  localparam logic [9:0]  COL_HI   = 10'(CNN_REAL_WIDTH - CNN_INPUT_PAD);
  localparam logic [9:0]  ROW_HI   = 10'(CNN_REAL_HEIGHT - CNN_INPUT_PAD);

  typedef enum logic [1:0] {IDLE, ARMED, STREAM, DONE} state_e;

  state_e          state_q;
  logic            doing_q, busy_q, done_q;

  logic [9:0]      idx_q, row_q, col_q;
  logic            issued_all_q;
  logic            infl_q, infl_pad_q, infl_last_q;
  logic [1:0][7:0] fifo_data_q;
  logic [1:0]      fifo_last_q;
  logic            rd_ptr_q, wr_ptr_q;
  logic [1:0]      cnt_q, cnt_d;

  logic            streaming, is_pad, issue, head_fifo, head_last;
  logic            hs, last_hs, push, pop;
  logic [7:0]      infl_data, head_data;

  always_comb begin
    streaming = (state_q == STREAM);
    is_pad    = (row_q < PAD_LO) || (row_q >= ROW_HI) ||
                (col_q < PAD_LO) || (col_q >= COL_HI);
    issue     = streaming && !issued_all_q &&
                (({1'b0, cnt_q} + {2'b00, infl_q}) < 3'd2);
    infl_data = infl_pad_q ? PAD_VALUE : rd_data;
    // An empty FIFO presents the in-flight element directly so the first pixel
    // appears the cycle its read data returns; a stalled one is caught next edge.
    head_fifo = (cnt_q != 2'd0);
    head_data = head_fifo ? fifo_data_q[rd_ptr_q] : infl_data;
    head_last = head_fifo ? fifo_last_q[rd_ptr_q] : infl_last_q;
    px_valid  = streaming && (head_fifo || infl_q);
    px_data   = px_valid ? head_data : '0;
    px_last   = px_valid && head_last;
    hs        = px_valid && px_ready;
    last_hs   = hs && head_last;
    pop       = hs && head_fifo;
    push      = infl_q && !(hs && !head_fifo);
    cnt_d     = cnt_q + {1'b0, push} - {1'b0, pop};
    rd_en     = issue && !is_pad;
    rd_addr   = rd_en ? idx_q : '0;
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      doing_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q <= ARMED;
          doing_q <= 1'b1;
          busy_q  <= 1'b1;
        end
        ARMED: if (lenet_data_ready) begin
          state_q <= STREAM;
          doing_q <= 1'b0;
        end
        STREAM: if (last_hs) begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      issued_all_q <= 1'b0;
      infl_q       <= 1'b0;
      infl_pad_q   <= 1'b0;
      infl_last_q  <= 1'b0;
      fifo_data_q  <= '0;
      fifo_last_q  <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      cnt_q        <= '0;
    end else if (!streaming) begin
      idx_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      issued_all_q <= 1'b0;
      infl_q       <= 1'b0;
      infl_pad_q   <= 1'b0;
      infl_last_q  <= 1'b0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      infl_q      <= issue;
      infl_pad_q  <= is_pad;
      infl_last_q <= (idx_q == LAST_IDX);
      if (issue) begin
        if (idx_q == LAST_IDX) begin
          issued_all_q <= 1'b1;
        end else begin
          idx_q <= idx_q + 10'd1;
          if (col_q == COL_MAX) begin
            col_q <= '0;
            row_q <= row_q + 10'd1;
          end else begin
            col_q <= col_q + 10'd1;
          end
        end
      end
      if (push) begin
        fifo_data_q[wr_ptr_q] <= infl_data;
        fifo_last_q[wr_ptr_q] <= infl_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_d;
    end
  end

  assign lenet_doing_signal = doing_q;
  assign busy               = busy_q;
  assign frame_done         = done_q;

endmodule

// File: tb/tb_lenet_input_reader.sv
// Directed bench for lenet_input_reader: expected pixel stream is queued when the
// frame is released and popped on every px_valid/px_ready handshake.
module tb_lenet_input_reader;

  localparam int W     = 32;
  localparam int H     = 32;
  localparam int P     = 2;
  localparam int N     = W * H;
  localparam int NREAD = (W - 2 * P) * (H - 2 * P);

  typedef struct packed {
    logic [9:0] idx;
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic       clk25 = 1'b0;
  logic       rst_n;
  logic       start = 1'b0, lenet_data_ready = 1'b0, px_ready = 1'b1;
  logic       lenet_doing_signal, rd_en, px_valid, px_last, busy, frame_done;
  logic [9:0] rd_addr;
  logic [7:0] rd_data = 8'h00, px_data;
  logic       doing_f, rd_en_f, px_valid_f, px_last_f, busy_f, done_f;
  logic [9:0] rd_addr_f;
  logic [7:0] rd_data_f = 8'h00, px_data_f;
  logic [7:0] mem [N];

  always #5 clk25 = ~clk25;

  lenet_input_reader dut (
    .clk25(clk25), .rst_n(rst_n), .start(start), .lenet_data_ready(lenet_data_ready),
    .lenet_doing_signal(lenet_doing_signal), .rd_addr(rd_addr), .rd_en(rd_en),
    .rd_data(rd_data), .px_data(px_data), .px_valid(px_valid), .px_ready(px_ready),
    .px_last(px_last), .busy(busy), .frame_done(frame_done)
  );

  lenet_input_reader #(.PAD_VALUE(8'hFF)) dut_f (
    .clk25(clk25), .rst_n(rst_n), .start(start), .lenet_data_ready(lenet_data_ready),
    .lenet_doing_signal(doing_f), .rd_addr(rd_addr_f), .rd_en(rd_en_f),
    .rd_data(rd_data_f), .px_data(px_data_f), .px_valid(px_valid_f), .px_ready(px_ready),
    .px_last(px_last_f), .busy(busy_f), .frame_done(done_f)
  );

  always @(posedge clk25) begin
    if (rd_en)   rd_data   <= mem[rd_addr];
    if (rd_en_f) rd_data_f <= mem[rd_addr_f];
  end

  int         vectors = 0, miscompares = 0;
  int         cyc, hs_frame, rd_cnt, rd_cnt_f, ff_cnt, rd_stall, last_hs_cyc, first_valid;
  int         ready_mode = 0;
  bit         timed = 0, frame_active = 0, idle_chk = 0, done_seen = 0, prev_stall = 0;
  logic [7:0] prev_data;
  logic       prev_last;
  exp_t       sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      automatic int r = i / W;
      automatic int c = i % W;
      e.idx  = 10'(i);
      e.data = (r < P || r >= H - P || c < P || c >= W - P) ? 8'h00 : 8'(i);
      e.last = (i == N - 1);
      sb.push_back(e);
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_doing"},      32'(lenet_doing_signal), 0);
    check({tag, "_rd_en"},      32'(rd_en), 0);
    check({tag, "_px_valid"},   32'(px_valid), 0);
    check({tag, "_px_last"},    32'(px_last), 0);
    check({tag, "_busy"},       32'(busy), 0);
    check({tag, "_frame_done"}, 32'(frame_done), 0);
    check({tag, "_rd_addr"},    32'(rd_addr), 0);
    check({tag, "_px_data"},    32'(px_data), 0);
  endtask

  task automatic observe();
    exp_t e;
    if (rd_en)   rd_cnt++;
    if (rd_en_f) rd_cnt_f++;
    if (ready_mode == 2 && (first_valid < 0 || cyc < first_valid + 100) && rd_en) rd_stall++;
    if (px_valid && first_valid < 0) first_valid = cyc;
    check("last_without_valid", 32'(px_last & ~px_valid), 0);
    if (idle_chk) begin
      check("idle_busy",  32'(busy), 0);
      check("idle_doing", 32'(lenet_doing_signal), 0);
      check("idle_valid", 32'(px_valid), 0);
      check("idle_rd_en", 32'(rd_en), 0);
      check("idle_done",  32'(frame_done), 0);
    end
    if (timed && cyc <= 12) begin
      check("doing_window", 32'(lenet_doing_signal), 32'(cyc >= 1 && cyc <= 10));
      check("busy_window",  32'(busy), 32'(cyc >= 1));
      check("first_valid",  32'(px_valid), 32'(cyc >= 12));
    end
    if (prev_stall) begin
      check("hold_valid", 32'(px_valid), 1);
      check("hold_data",  32'(px_data), 32'(prev_data));
      check("hold_last",  32'(px_last), 32'(prev_last));
    end
    if (px_valid && px_ready) begin
      vectors++;
      assert (sb.size() != 0) else begin
        miscompares++;
        $error("FAIL extra_pixel: observed handshake %0d, expected at most %0d", hs_frame + 1, N);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("px_data", 32'(px_data), 32'(e.data));
        check("px_last", 32'(px_last), 32'(e.last));
        if (timed && e.idx == 10'd66) check("px66_data", 32'(px_data), 32'h42);
        if (timed && e.idx == 10'd1023) begin
          check("px1023_data", 32'(px_data), 0);
          check("px1023_last", 32'(px_last), 1);
        end
        if (e.last) last_hs_cyc = cyc;
      end
      hs_frame++;
    end
    if (px_valid_f && px_ready && px_data_f == 8'hFF) ff_cnt++;
    if (frame_active) check("frame_done", 32'(frame_done), 32'(cyc == last_hs_cyc + 1));
    if (timed && cyc == 1036) check("done_at_1036", 32'(frame_done), 1);
    if (frame_done) done_seen = 1;
    prev_stall = px_valid && !px_ready;
    prev_data  = px_data;
    prev_last  = px_last;
  endtask

  // Observe the current cycle at the falling edge, then step into the next one.
  task automatic tick();
    @(negedge clk25);
    observe();
    @(posedge clk25);
    #1;
    cyc++;
    case (ready_mode)
      1:       px_ready = 1'($urandom_range(0, 1));
      2:       px_ready = (first_valid >= 0 && cyc >= first_valid + 100);
      default: px_ready = 1'b1;
    endcase
  endtask

  task automatic idle(input int n);
    idle_chk = 1;
    repeat (n) tick();
    idle_chk = 0;
  endtask

  task automatic run_frame(input int mode, input bit tmd, input int abort_at);
    cyc = 0; hs_frame = 0; rd_cnt = 0; rd_cnt_f = 0; ff_cnt = 0; rd_stall = 0;
    last_hs_cyc = -10; first_valid = -1; done_seen = 0; prev_stall = 0;
    ready_mode = mode; timed = tmd;
    px_ready = (mode == 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < 10) tick();
    lenet_data_ready = 1'b1;
    push_frame();
    frame_active = 1;
    tick();
    lenet_data_ready = 1'b0;
    while (!done_seen && cyc < 6000 && !(abort_at > 0 && hs_frame >= abort_at)) begin
      start = (cyc == 300);
      tick();
    end
    start = 1'b0;
    timed = 0;
    if (abort_at == 0) begin
      check("frame_completed", 32'(done_seen), 1);
      check("handshakes",      32'(hs_frame), 32'(N));
      check("scoreboard_left", 32'(sb.size()), 0);
      check("rd_pulses",       32'(rd_cnt), 32'(NREAD));
      check("rd_pulses_padff", 32'(rd_cnt_f), 32'(NREAD));
      check("pad_ff_pixels",   32'(ff_cnt), 32'(N - NREAD));
      if (mode == 2) check("stall_rd_at_most_2", 32'(rd_stall <= 2), 1);
      frame_active = 0;
      ready_mode = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no completion, expected summary before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < N; i++) mem[i] = 8'(i);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 reset_checks("reset");
    repeat (2) @(posedge clk25);
    #1 rst_n = 1'b1;

    idle(4);
    idle_chk = 1;
    lenet_data_ready = 1'b1;
    tick();
    lenet_data_ready = 1'b0;
    idle(6);

    run_frame(0, 1, 0);
    idle(20);
    run_frame(1, 0, 0);
    idle(10);
    run_frame(2, 0, 0);
    idle(10);

    run_frame(0, 0, 500);
    #2 rst_n = 1'b0;
    #1 reset_checks("midstream_reset");
    frame_active = 0;
    prev_stall = 0;
    ready_mode = 0;
    sb.delete();
    repeat (2) @(posedge clk25);
    #1 rst_n = 1'b1;
    idle(10);
    run_frame(0, 1, 0);
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lenet_input_reader.md
LENET_INPUT_READER -- requirements
Module: lenet_input_reader

Interface
REQ-001 SHALL have parameter CNN_REAL_WIDTH, default 32: padded CNN input width in pixels.
REQ-002 SHALL have parameter CNN_REAL_HEIGHT, default 32: padded CNN input height in pixels.
REQ-003 SHALL have parameter CNN_INPUT_PAD, default 2: border width of pad pixels on each side.
REQ-004 SHALL have parameter PAD_VALUE, default 8'h00: value emitted for pad pixels.
REQ-005 SHALL have port clk25, input, 1: clock.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1: request capture and streaming of one CNN frame.
REQ-008 SHALL have port lenet_data_ready, input, 1: one-cycle pulse; the capture buffer is fully written.
REQ-009 SHALL have port lenet_doing_signal, output, 1: request to the capture stage to fill the buffer on its next frame.
REQ-010 SHALL have port rd_addr, output, 10: capture buffer read address.
REQ-011 SHALL have port rd_en, output, 1: capture buffer read enable.
REQ-012 SHALL have port rd_data, input, 8: buffer data, valid exactly 1 cycle after rd_en.
REQ-013 SHALL have port px_data, output, 8: pixel to the CNN.
REQ-014 SHALL have port px_valid, output, 1: px_data is valid.
REQ-015 SHALL have port px_ready, input, 1: CNN accepts the pixel.
REQ-016 SHALL have port px_last, output, 1: marks pixel index 1023 (last pixel).
REQ-017 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-018 SHALL have port frame_done, output, 1: one-cycle pulse after the last pixel is accepted.

Function
REQ-019 SHALL implement the FSM IDLE -> ARMED (on start) -> STREAM (on lenet_data_ready) -> DONE (on last handshake) -> IDLE (after 1 cycle).
REQ-020 SHALL drive lenet_doing_signal high only in ARMED, deasserting it the cycle after lenet_data_ready is sampled.
REQ-021 SHALL ignore start outside IDLE and ignore lenet_data_ready outside ARMED.
REQ-022 SHALL stream indices i = 0..N-1 (N = CNN_REAL_WIDTH*CNN_REAL_HEIGHT) in raster order, where row = i / CNN_REAL_WIDTH and col = i % CNN_REAL_WIDTH.
REQ-023 SHALL treat index i as a pad pixel when row or col < CNN_INPUT_PAD, or row or col >= REAL - CNN_INPUT_PAD; a pad pixel issues no read, emits PAD_VALUE, and passes through the same 1-cycle stage as a read pixel.
REQ-024 SHALL read each non-pad pixel with rd_addr = i and rd_en = 1 for exactly one cycle; rd_en SHALL be 0 whenever no read is issued.
REQ-025 SHALL buffer output in a 2-entry FIFO.
REQ-026 SHALL issue a new element (read or pad) only when FIFO occupancy plus in-flight elements is less than 2, so no data is ever dropped.
REQ-027 SHALL complete a handshake when px_valid and px_ready are both high.
REQ-028 SHALL hold px_data and px_last stable while px_valid = 1 and px_ready = 0.
REQ-029 SHALL never drop px_valid without a handshake.
REQ-030 SHALL meet the following latency: lenet_data_ready sampled at cycle T puts the FSM in STREAM at T+1, issues index 0 at T+1, and asserts the first px_valid at T+2.
REQ-031 SHALL, with px_ready held at 1, sustain 1 pixel per cycle, so the last handshake occurs at T+2+N-1 and frame_done pulses at T+2+N.
REQ-032 SHALL assert px_last only together with px_valid, on index N-1.
REQ-033 SHALL use a 10-bit index counter that stops at N-1 and never wraps.
REQ-034 SHALL flush the FIFO to empty and clear the counter on DONE.

Reset
REQ-035 SHALL, on rst_n low at any time including mid-stream, immediately enter IDLE and clear the FIFO, counter, and in-flight tag.
REQ-036 SHALL, during reset, hold lenet_doing_signal, rd_en, px_valid, px_last, busy, and frame_done at 0, and rd_addr and px_data at 0.
REQ-037 SHALL, after reset release, require a new start before any activity.

Verification
REQ-038 SHALL verify that start at cycle 0, then lenet_data_ready at cycle 10, with px_ready = 1 and buffer[i] = i[7:0] gives: lenet_doing_signal high at cycles 1-10; first px_valid at cycle 12 with px_data = 0; index 66 (row 2, col 2) gives px_data = 8'h42; index 1023 gives px_data = 0 with px_last = 1; frame_done at cycle 1036.
REQ-039 SHALL verify that with px_ready toggling randomly at 50% duty, exactly 1024 handshakes occur, the sequence is identical to the no-stall run, and px_data never changes while stalled.
REQ-040 SHALL verify that with px_ready held at 0 for 100 cycles after the first px_valid, rd_en pulses at most 2 times in total, and releasing px_ready resumes the sequence without loss.
REQ-041 SHALL verify that with PAD_VALUE = 8'hFF, exactly 240 of 1024 pixels are 8'hFF pads and rd_en pulses exactly 784 times.
REQ-042 SHALL verify that lenet_data_ready pulsed in IDLE, and start pulsed during STREAM, cause no state change and no extra frame.
REQ-043 SHALL verify that asserting rst_n low at pixel 500 drives all outputs to 0 within the same cycle, and that a new start plus lenet_data_ready then restarts the stream at index 0.
